// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for seq_multiplier: FSM state encoding and default width.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, registered
// product, valid/ready handshake on operand and result sides.
// Optional macro SEQ_MULT_SIGNED_EN: two's-complement operands and product
// (magnitudes are multiplied, sign applied when the result is registered).
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a_load;
  logic [WIDTH-1:0]   b_load;
  logic               last;
`ifdef SEQ_MULT_SIGNED_EN
  logic               neg;
`endif

  assign in_ready = (state == ST_IDLE);
  assign last     = (cnt == CNT_W'(WIDTH - 1));

  // Operand conditioning, this cycle's partial-product add and final result.
  always_comb begin
    acc_sum = acc + (mplier[0] ? mcand : '0);
`ifdef SEQ_MULT_SIGNED_EN
    a_load  = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_load  = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    result  = neg ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
`else
    a_load  = a;
    b_load  = b;
    result  = acc_sum;
`endif
  end

  // Next-state logic: accept in IDLE, iterate WIDTH times, hold until consumed.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (in_valid) state_next = ST_BUSY;
      ST_BUSY: if (last)     state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Datapath: load operands on accept, shift-add while busy, capture result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      out_valid <= (state_next == ST_DONE);
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, a_load};
            mplier <= b_load;
            acc    <= '0;
            cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
          end
        end
        ST_BUSY: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) prod <= result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: a WIDTH=8 and a WIDTH=16 instance,
// checked against a plain-arithmetic product model.
module tb_seq_multiplier;
  import seq_multiplier_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic        in_ready8, out_valid8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] prod8;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic        in_ready16, out_valid16;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] prod16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .prod(prod8)
  );

  seq_multiplier #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .prod(prod16)
  );

  // Reference product of two w-bit operands, low 2*w bits.
  function automatic logic [31:0] ref_mul(input int unsigned w, input logic [15:0] x,
                                          input logic [15:0] y);
    longint sa, sb, p, mask;
    mask = (longint'(1) << w) - 1;
    sa = longint'(x) & mask;
    sb = longint'(y) & mask;
`ifdef SEQ_MULT_SIGNED_EN
    if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
`endif
    p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    return 32'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the 8-bit instance (starts/ends in IDLE).
  task automatic do_op8(input logic [7:0] x, input logic [7:0] y,
                        output logic [15:0] p, output int lat);
    a8 = x; b8 = y; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      tick();
      lat++;
    end
    p = prod8;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
  endtask

  task automatic do_op16(input logic [15:0] x, input logic [15:0] y,
                         output logic [31:0] p, output int lat);
    a16 = x; b16 = y; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 200) begin
      tick();
      lat++;
    end
    p = prod16;
    out_ready16 = 1'b1;
    tick();
    out_ready16 = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] p;
    int lat;
    bit spurious;
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
    n_cmp++; if (prod8 !== 16'd0) begin n_err++; $display("FAIL reset_prod got=%h exp=0000", prod8); end
    n_cmp++; if (prod16 !== 32'd0) begin n_err++; $display("FAIL reset_prod16 got=%h exp=00000000", prod16); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
    // Reset three edges into a 7*9 operation.
    a8 = 8'd7; b8 = 8'd9; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL midbusy_out_valid got=%b exp=0", out_valid8); end
    n_cmp++; if (prod8 !== 16'd0) begin n_err++; $display("FAIL midbusy_prod got=%h exp=0000", prod8); end
    n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL midbusy_in_ready got=%b exp=1", in_ready8); end
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid8 !== 1'b0) spurious = 1'b1;
      tick();
    end
    n_cmp++; if (spurious !== 1'b0) begin n_err++; $display("FAIL midbusy_discard got=%b exp=0", spurious); end
    do_op8(8'd3, 8'd5, p, lat);
    n_cmp++; if (p !== 16'd15) begin n_err++; $display("FAIL post_reset_prod got=%h exp=000f", p); end
  endtask

  task automatic test_latency();
    logic [15:0] exp_p;
    int lat;
    bit busy_ready;
`ifdef SEQ_MULT_SIGNED_EN
    exp_p = 16'h0001;
`else
    exp_p = 16'hFE01;
`endif
    a8 = 8'd255; b8 = 8'd255; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    busy_ready = 1'b0;
    while (!out_valid8 && lat < 200) begin
      if (in_ready8 !== 1'b0) busy_ready = 1'b1;
      tick();
      lat++;
    end
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL latency8 got=%0d exp=8", lat); end
    n_cmp++; if (busy_ready !== 1'b0) begin n_err++; $display("FAIL busy_in_ready got=%b exp=0", busy_ready); end
    n_cmp++; if (prod8 !== exp_p) begin n_err++; $display("FAIL max_prod got=%h exp=%h", prod8, exp_p); end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL handshake_drop got=%b exp=0", out_valid8); end
  endtask

  task automatic test_backpressure();
    int lat;
    bit held_bad;
    a8 = 8'd12; b8 = 8'd10; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL bp_latency got=%0d exp=8", lat); end
    held_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); in_valid8 = 1'($urandom);
      if (out_valid8 !== 1'b1 || prod8 !== 16'd120 || in_ready8 !== 1'b0) held_bad = 1'b1;
      tick();
    end
    in_valid8 = 1'b0;
    n_cmp++; if (held_bad !== 1'b0) begin n_err++; $display("FAIL bp_hold got=%b exp=0", held_bad); end
    n_cmp++; if (prod8 !== 16'd120) begin n_err++; $display("FAIL bp_prod got=%h exp=0078", prod8); end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL bp_release got=%b exp=1", in_ready8); end
    n_cmp++; if (prod8 !== 16'd120) begin n_err++; $display("FAIL bp_prod_kept got=%h exp=0078", prod8); end
  endtask

  task automatic test_early_ready();
    int lat;
    // out_ready asserted throughout BUSY must not shorten or skip the result.
    out_ready8 = 1'b1;
    a8 = 8'd0; b8 = 8'd77; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL early_ready_latency got=%0d exp=8", lat); end
    n_cmp++; if (prod8 !== 16'd0) begin n_err++; $display("FAIL zero_prod8 got=%h exp=0000", prod8); end
    tick();
    out_ready8 = 1'b0;
    n_cmp++; if (out_valid8 !== 1'b0) begin n_err++; $display("FAIL early_ready_drop got=%b exp=0", out_valid8); end
  endtask

  task automatic test_width16();
    logic [31:0] p, exp_p;
    int lat;
    do_op16(16'd0, 16'hFFFF, p, lat);
    n_cmp++; if (lat != 16) begin n_err++; $display("FAIL latency16 got=%0d exp=16", lat); end
    n_cmp++; if (p !== 32'd0) begin n_err++; $display("FAIL zero_prod16 got=%h exp=00000000", p); end
`ifdef SEQ_MULT_SIGNED_EN
    exp_p = 32'h0000_0001;
`else
    exp_p = 32'hFFFE_0001;
`endif
    do_op16(16'hFFFF, 16'hFFFF, p, lat);
    n_cmp++; if (p !== exp_p) begin n_err++; $display("FAIL max_prod16 got=%h exp=%h", p, exp_p); end
    for (int i = 0; i < 6; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom); y = 16'($urandom);
      exp_p = ref_mul(16, x, y);
      do_op16(x, y, p, lat);
      n_cmp++; if (p !== exp_p) begin n_err++; $display("FAIL rand16 a=%h b=%h got=%h exp=%h", x, y, p, exp_p); end
    end
  endtask

  task automatic test_random8();
    logic [15:0] p;
    logic [31:0] e;
    logic [7:0] x, y;
    int lat;
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      if (i == 0) x = 8'h80;
      if (i == 1) y = 8'h7F;
      e = ref_mul(8, {8'd0, x}, {8'd0, y});
      do_op8(x, y, p, lat);
      n_cmp++; if (p !== e[15:0] || lat != 8) begin
        n_err++; $display("FAIL rand8 a=%h b=%h got=%h/%0d exp=%h/8", x, y, p, lat, e[15:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] pair;
    logic [31:0] e;
    int results, last_cyc, cyc;
    results = 0;
    last_cyc = -1;
    out_ready8 = 1'b1;
    in_valid8 = 1'b1;
    for (cyc = 0; cyc < 75; cyc++) begin
      if (out_valid8) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL b2b_unexpected got=1 exp=0");
        end else begin
          pair = q.pop_front();
          e = ref_mul(8, {8'd0, pair[15:8]}, {8'd0, pair[7:0]});
          n_cmp++; if (prod8 !== e[15:0]) begin
            n_err++; $display("FAIL b2b_prod a=%h b=%h got=%h exp=%h", pair[15:8], pair[7:0], prod8, e[15:0]);
          end
        end
        if (last_cyc >= 0) begin
          n_cmp++; if (cyc - last_cyc != 10) begin
            n_err++; $display("FAIL b2b_interval got=%0d exp=10", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        results++;
      end
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (in_ready8) q.push_back({a8, b8});
      tick();
    end
    in_valid8 = 1'b0;
    n_cmp++; if (results < 6) begin n_err++; $display("FAIL b2b_count got=%0d exp>=6", results); end
    // Drain whatever is in flight so the instance is idle afterwards.
    for (int i = 0; i < 12; i++) tick();
    out_ready8 = 1'b0;
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed();
    logic [15:0] p;
    int lat;
    do_op8(8'h80, 8'h80, p, lat);
    n_cmp++; if (p !== 16'h4000) begin n_err++; $display("FAIL signed_minmin got=%h exp=4000", p); end
    do_op8(8'h80, 8'h01, p, lat);
    n_cmp++; if (p !== 16'hFF80) begin n_err++; $display("FAIL signed_min1 got=%h exp=ff80", p); end
    do_op8(8'hFD, 8'd5, p, lat);
    n_cmp++; if (p !== 16'hFFF1) begin n_err++; $display("FAIL signed_m3x5 got=%h exp=fff1", p); end
    n_cmp++; if (lat != 8) begin n_err++; $display("FAIL signed_latency got=%0d exp=8", lat); end
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_latency();
    test_backpressure();
    test_early_ready();
    test_width16();
    test_random8();
    test_back_to_back();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
